echo_measure_sequencer: RTL and testbench

- Sequences one complete multi-shot ultrasound measurement: transducer relay settle, launch burst, blanking, AD capture start, and wait for the correlator result.
- Averages N shots and emits one averaged time-of-flight plus the peak correlation value.
- Sits between the command decoder and the launch/AD/Echo_Correlation chain, and replaces fixed-timing single-shot triggering.
- Handles abort, per-shot timeout and ignored re-triggers.

---
 rtl/echo_measure_sequencer.sv | 147 ++++++++++++++
 tb/tb_echo_measure_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_measure_sequencer.sv
// Multi-shot ultrasound measurement sequencer: relay settle, launch, blanking,
// AD start and correlator wait, repeated 2^AVG_LOG2 times, then one averaged report.
module echo_measure_sequencer #(
    parameter int SETTLE_CYC  = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int TIMEOUT_CYC = 2500000,
    parameter int GAP_CYC     = 500000,
    parameter int AVG_LOG2    = 2
) (
    input  logic        clk_50M,
    input  logic        rst,
    input  logic        meas_start,
    input  logic        meas_abort,
    input  logic        processing_done,
    input  logic [19:0] echo_tof,
    input  logic [17:0] echo_peak,
    output logic        relay,
    output logic        exc_start,
    output logic        sys_start_pulse,
    output logic        ad_start,
    output logic [19:0] result_tof,
    output logic [17:0] result_peak,
    output logic        result_valid,
    output logic        busy,
    output logic        timeout_err,
    output logic [3:0]  shot_idx
);

    localparam int MAX_SB  = (SETTLE_CYC > BLANK_CYC) ? SETTLE_CYC : BLANK_CYC;
    localparam int MAX_TG  = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_SB > MAX_TG) ? MAX_SB : MAX_TG;
    localparam int CNT_W   = $clog2(MAX_CYC + 1) + 1;
    // Exact width of the sum of 2^AVG_LOG2 twenty-bit samples, so it never overflows
    localparam int ACC_W   = 20 + AVG_LOG2;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
    localparam logic [3:0]       LAST_SHOT    = 4'((1 << AVG_LOG2) - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_FIRE    = 3'd2;
    localparam logic [2:0] S_BLANK   = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;
    localparam logic [2:0] S_GAP     = 3'd6;
    localparam logic [2:0] S_REPORT  = 3'd7;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [17:0]      peak_max;
    logic             abort;
    logic             accept;
    logic             tmo;

    assign abort = meas_abort && (state != S_IDLE);

    // Abort overrides both an arriving result and a timeout
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        tmo       = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (meas_start) state_nxt = S_SETTLE;
                S_SETTLE:  if (cnt == SETTLE_LAST) state_nxt = S_FIRE;
                S_FIRE:    state_nxt = S_BLANK;
                S_BLANK:   if (cnt == BLANK_LAST) state_nxt = S_CAPTURE;
                S_CAPTURE: state_nxt = S_WAIT;
                S_WAIT: begin
                    if (processing_done) begin
                        accept    = 1'b1;
                        state_nxt = (shot_idx == LAST_SHOT) ? S_REPORT : S_GAP;
                    end else if (cnt >= TIMEOUT_LAST) begin
                        tmo       = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_GAP:     if (cnt == GAP_LAST) state_nxt = S_FIRE;
                S_REPORT:  state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            relay        <= 1'b0;
            timeout_err  <= 1'b0;
            shot_idx     <= 4'd0;
            acc          <= '0;
            peak_max     <= '0;
            result_tof   <= '0;
            result_peak  <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            result_valid <= 1'b0;
            // Timeout is measured from the ad_start cycle, so WAIT_DONE starts at 1
            if (state_nxt != state)
                cnt <= (state_nxt == S_WAIT) ? CNT_W'(1) : '0;
            else if (cnt != {CNT_W{1'b1}})
                cnt <= cnt + CNT_W'(1);

            if (state == S_IDLE && meas_start) begin
                relay       <= 1'b1;
                timeout_err <= 1'b0;
                shot_idx    <= 4'd0;
                acc         <= '0;
                peak_max    <= '0;
            end
            if (accept) begin
                acc <= acc + ACC_W'(echo_tof);
                if (echo_peak > peak_max)
                    peak_max <= echo_peak;
                if (shot_idx != LAST_SHOT)
                    shot_idx <= shot_idx + 4'd1;
            end
            if (tmo) begin
                timeout_err <= 1'b1;
                relay       <= 1'b0;
            end
            if (abort)
                relay <= 1'b0;
            if (state == S_REPORT && !abort) begin
                result_tof   <= acc[AVG_LOG2 +: 20];
                result_peak  <= peak_max;
                result_valid <= 1'b1;
                relay        <= 1'b0;
            end
        end
    end

    assign exc_start       = (state == S_FIRE);
    assign sys_start_pulse = (state == S_FIRE);
    assign ad_start        = (state == S_CAPTURE);
    assign busy            = (state != S_IDLE);

endmodule

// File: tb/tb_echo_measure_sequencer.sv
// Bench for echo_measure_sequencer: table vectors, random shots against an
// event-timing model, and hand sequences for timeout, abort and re-trigger cases.
module tb_echo_measure_sequencer;

    localparam int SETTLE = 10;
    localparam int BLANK  = 5;
    localparam int TMO    = 50;
    localparam int GAP    = 8;
    localparam int L2     = 2;
    localparam int NSH    = 4;

    typedef struct {
        logic [3:0][7:0]  dly;
        logic [3:0][19:0] tof;
        logic [3:0][17:0] peak;
        logic [19:0]      exp_tof;
        logic [17:0]      exp_peak;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        meas_start = 0, meas_abort = 0, processing_done = 0;
    logic [19:0] echo_tof = '0;
    logic [17:0] echo_peak = '0;
    logic        relay, exc_start, sys_start_pulse, ad_start, result_valid, busy, timeout_err;
    logic [19:0] result_tof;
    logic [17:0] result_peak;
    logic [3:0]  shot_idx;

    logic        start2 = 0, abort2 = 0, done2 = 0;
    logic [19:0] tof2 = '0;
    logic [17:0] peak2 = '0;
    logic        relay2, exc2, sys2, ad2, rv2, busy2, terr2;
    logic [19:0] rtof2;
    logic [17:0] rpeak2;
    logic [3:0]  sidx2;

    echo_measure_sequencer #(
        .SETTLE_CYC(SETTLE), .BLANK_CYC(BLANK), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP), .AVG_LOG2(L2)
    ) dut (
        .clk_50M(clk), .rst(rst), .meas_start(meas_start), .meas_abort(meas_abort),
        .processing_done(processing_done), .echo_tof(echo_tof), .echo_peak(echo_peak),
        .relay(relay), .exc_start(exc_start), .sys_start_pulse(sys_start_pulse),
        .ad_start(ad_start), .result_tof(result_tof), .result_peak(result_peak),
        .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err), .shot_idx(shot_idx)
    );

    echo_measure_sequencer #(
        .SETTLE_CYC(SETTLE), .BLANK_CYC(BLANK), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP), .AVG_LOG2(0)
    ) dut2 (
        .clk_50M(clk), .rst(rst), .meas_start(start2), .meas_abort(abort2),
        .processing_done(done2), .echo_tof(tof2), .echo_peak(peak2),
        .relay(relay2), .exc_start(exc2), .sys_start_pulse(sys2),
        .ad_start(ad2), .result_tof(rtof2), .result_peak(rpeak2),
        .result_valid(rv2), .busy(busy2), .timeout_err(terr2), .shot_idx(sidx2)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    int exc_q[$];
    int ad_q[$];
    int rv_q[$];
    int rv2_cnt = 0;
    int sys_mis = 0;
    logic [19:0] last_tof = '0;
    logic [17:0] last_peak = '0;

    always @(negedge clk) begin
        if (exc_start) exc_q.push_back(cyc);
        if (ad_start) ad_q.push_back(cyc);
        if (result_valid) rv_q.push_back(cyc);
        if (sys_start_pulse !== exc_start) sys_mis++;
        if (rv2) rv2_cnt++;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exc_q.delete();
        ad_q.delete();
        rv_q.delete();
    endtask

    task automatic pulse_start();
        tick();
        meas_start = 1'b1;
        tick();
        meas_start = 1'b0;
    endtask

    // Wait for the next ad_start, then answer dly cycles later (optionally with abort)
    task automatic serve_shot(input int dly, input logic [19:0] t, input logic [17:0] p,
                              input bit ab, output int adc);
        adc = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (ad_start) begin
                adc = cyc;
                break;
            end
        end
        if (adc < 0) begin
            chk("ad_start arrival", 0, 1);
            return;
        end
        repeat (dly) @(posedge clk);
        #1;
        processing_done = 1'b1;
        echo_tof        = t;
        echo_peak       = p;
        meas_abort      = ab;
        tick();
        processing_done = 1'b0;
        meas_abort      = 1'b0;
    endtask

    task automatic run_shots(input vec_t v, input bit inject);
        int s, e, a, d, adc, rvc;
        int exp_exc[NSH];
        int exp_ad[NSH];
        logic rel, bsy;
        clear_q();
        tick();
        meas_start = 1'b1;
        s = cyc;
        tick();
        meas_start = 1'b0;
        chk("relay after start", relay, 1);
        chk("busy after start", busy, 1);
        for (int i = 0; i < NSH; i++) begin
            serve_shot(int'(v.dly[i]), v.tof[i], v.peak[i], 1'b0, adc);
            if (inject && i == 0) begin
                tick();
                meas_start      = 1'b1;
                processing_done = 1'b1;
                echo_tof        = '1;
                echo_peak       = '1;
                tick();
                meas_start      = 1'b0;
                processing_done = 1'b0;
            end
        end
        rvc = -1;
        rel = 1'b1;
        bsy = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (result_valid) begin
                rvc = cyc;
                rel = relay;
                bsy = busy;
                break;
            end
        end
        // Event timing from the sequence rules
        e = s + 1 + SETTLE;
        d = 0;
        for (int i = 0; i < NSH; i++) begin
            exp_exc[i] = e;
            a          = e + 1 + BLANK;
            exp_ad[i]  = a;
            d          = a + int'(v.dly[i]);
            e          = d + 1 + GAP;
        end
        chk("exc_start count", exc_q.size(), NSH);
        chk("ad_start count", ad_q.size(), NSH);
        for (int i = 0; i < NSH; i++) begin
            if (i < exc_q.size()) chk("exc_start cycle", exc_q[i], exp_exc[i]);
            if (i < ad_q.size()) chk("ad_start cycle", ad_q[i], exp_ad[i]);
        end
        chk("result_valid cycle", rvc, d + 2);
        chk("result_tof", result_tof, v.exp_tof);
        chk("result_peak", result_peak, v.exp_peak);
        chk("relay at result_valid", rel, 0);
        chk("busy at result_valid", bsy, 0);
        chk("timeout_err after good run", timeout_err, 0);
        repeat (3) tick();
        chk("result_valid count", rv_q.size(), 1);
        last_tof  = v.exp_tof;
        last_peak = v.exp_peak;
    endtask

    vec_t vecs[4];
    vec_t rv;

    initial begin
        int adc, tc, e_cyc, sum;
        logic rel, bsy;
        logic [17:0] pmax;

        // index 3 is listed first in each packed concatenation
        vecs[0].dly  = {8'd3, 8'd3, 8'd3, 8'd3};
        vecs[0].tof  = {20'd103, 20'd102, 20'd101, 20'd100};
        vecs[0].peak = {18'd29, 18'd12, 18'd30, 18'd7};
        vecs[0].exp_tof = 20'd101;  vecs[0].exp_peak = 18'd30;
        vecs[1].dly  = {8'd49, 8'd5, 8'd2, 8'd49};
        vecs[1].tof  = {20'd44, 20'd30, 20'd20, 20'd10};
        vecs[1].peak = {18'd4, 18'd3, 18'd2, 18'd1};
        vecs[1].exp_tof = 20'd26;   vecs[1].exp_peak = 18'd4;
        vecs[2].dly  = {8'd40, 8'd30, 8'd20, 8'd10};
        vecs[2].tof  = {20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF};
        vecs[2].peak = {18'd2, 18'd1, 18'd0, 18'h3FFFF};
        vecs[2].exp_tof = 20'hFFFFF; vecs[2].exp_peak = 18'h3FFFF;
        vecs[3].dly  = {8'd1, 8'd1, 8'd1, 8'd1};
        vecs[3].tof  = {20'd0, 20'd0, 20'd0, 20'd7};
        vecs[3].peak = {18'd6, 18'd4, 18'd5, 18'd5};
        vecs[3].exp_tof = 20'd1;    vecs[3].exp_peak = 18'd6;

        repeat (3) tick();
        rst = 1'b0;
        chk("reset relay", relay, 0);
        chk("reset busy", busy, 0);
        chk("reset exc_start", exc_start, 0);
        chk("reset ad_start", ad_start, 0);
        chk("reset result_valid", result_valid, 0);
        chk("reset result_tof", result_tof, 0);
        chk("reset result_peak", result_peak, 0);
        chk("reset timeout_err", timeout_err, 0);
        chk("reset shot_idx", shot_idx, 0);

        for (int i = 0; i < 4; i++) run_shots(vecs[i], 1'b0);

        // Stray start and done during GAP must not disturb the measurement
        run_shots(vecs[0], 1'b1);

        for (int r = 0; r < 6; r++) begin
            sum  = 0;
            pmax = '0;
            for (int i = 0; i < NSH; i++) begin
                rv.dly[i]  = 8'($urandom_range(1, TMO - 1));
                rv.tof[i]  = 20'($urandom);
                rv.peak[i] = 18'($urandom);
                sum += int'(rv.tof[i]);
                if (rv.peak[i] > pmax) pmax = rv.peak[i];
            end
            rv.exp_tof  = 20'(sum / NSH);
            rv.exp_peak = pmax;
            run_shots(rv, 1'b0);
        end

        // Timeout on the second shot
        clear_q();
        pulse_start();
        serve_shot(3, 20'd500, 18'd9, 1'b0, adc);
        adc = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ad_start) begin adc = cyc; break; end
        end
        tc = -1; rel = 1'b1; bsy = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (timeout_err) begin tc = cyc; rel = relay; bsy = busy; break; end
        end
        chk("timeout cycle", tc, adc + TMO);
        chk("relay at timeout", rel, 0);
        chk("busy at timeout", bsy, 0);
        repeat (3) tick();
        chk("no result_valid on timeout", rv_q.size(), 0);
        chk("result_tof held on timeout", result_tof, last_tof);
        pulse_start();
        chk("timeout_err cleared by start", timeout_err, 0);
        meas_abort = 1'b1;
        tick();
        meas_abort = 1'b0;
        chk("busy after abort in SETTLE", busy, 0);

        // Abort during BLANK of shot 1
        clear_q();
        pulse_start();
        serve_shot(3, 20'd700, 18'd11, 1'b0, adc);
        e_cyc = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exc_start) begin e_cyc = cyc; break; end
        end
        chk("second exc_start seen", e_cyc >= 0, 1);
        tick();
        meas_abort = 1'b1;
        tick();
        meas_abort = 1'b0;
        chk("busy after BLANK abort", busy, 0);
        chk("relay after BLANK abort", relay, 0);
        repeat (20) tick();
        chk("ad_start count after abort", ad_q.size(), 1);
        chk("no result_valid after abort", rv_q.size(), 0);
        chk("result_tof held after abort", result_tof, last_tof);
        chk("result_peak held after abort", result_peak, last_peak);

        // Abort coincident with the final processing_done
        clear_q();
        pulse_start();
        for (int i = 0; i < NSH - 1; i++) serve_shot(2, 20'd50, 18'd3, 1'b0, adc);
        serve_shot(2, 20'd50, 18'd3, 1'b1, adc);
        chk("busy after done+abort", busy, 0);
        chk("relay after done+abort", relay, 0);
        repeat (5) tick();
        chk("no result_valid on done+abort", rv_q.size(), 0);
        chk("result_tof held on done+abort", result_tof, last_tof);

        // Single-shot instance with full-scale inputs
        tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        adc = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ad2) begin adc = cyc; break; end
        end
        repeat (2) @(posedge clk);
        #1;
        done2 = 1'b1; tof2 = 20'hFFFFF; peak2 = 18'h3FFFF;
        tick();
        done2 = 1'b0;
        tc = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rv2) begin tc = cyc; break; end
        end
        chk("single-shot result_valid cycle", tc, adc + 4);
        chk("single-shot result_tof", rtof2, 20'hFFFFF);
        chk("single-shot result_peak", rpeak2, 18'h3FFFF);
        repeat (3) tick();
        chk("single-shot result_valid count", rv2_cnt, 1);

        // Reset in the middle of a sequence
        pulse_start();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid reset relay", relay, 0);
        chk("mid reset busy", busy, 0);
        chk("mid reset result_tof", result_tof, 0);
        chk("mid reset result_peak", result_peak, 0);
        chk("mid reset single-shot result_tof", rtof2, 0);

        chk("sys_start_pulse tracks exc_start", sys_mis, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
